bnn_frame_ctrl: RTL
===================

Name: bnn_frame_ctrl

Overview:
Sequencer that wraps the combinational net64 BNN top-level as a multicycle datapath. It accepts a binary input frame row by row over a valid/ready stream and holds it stable on the BNN input. It waits a programmed settle time, then captures the class scores and reduces them to an argmax. The result is presented on a valid/ready output, and the block sits between the image front-end and the host/result sink.

Parameters:
ROW_W, 64, bits per frame row (BNN input width)
ROWS, 64, rows per frame (BNN input height)
N_CLASS, 3, number of BNN output scores
SCORE_W, 7, width of each score (unsigned)
SETTLE_CYCLES, 8, cycles the frame is held before capture; legal range >=1
CLS_W, $clog2(N_CLASS), class index width (derived, min 1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async reset, active-low
clear_i  in  1  synchronous abort; returns FSM to IDLE
row_i  in  ROW_W  frame row data
row_valid_i  in  1  row valid
row_ready_o  out  1  row accepted when valid&ready
bnn_layer_o  out  ROWS*ROW_W  frame buffer to BNN layer_i; row r at [r*ROW_W +: ROW_W]
bnn_scores_i  in  N_CLASS*SCORE_W  BNN layer_o; class k at [k*SCORE_W +: SCORE_W]
busy_o  out  1  high in every state except IDLE
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed when valid&ready
res_class_o  out  CLS_W  argmax class index
res_score_o  out  SCORE_W  winning score
res_scores_o  out  N_CLASS*SCORE_W  all captured scores

Behaviour:
- Reset (rst_ni=0, async): FSM=IDLE, row counter=0, settle counter=0, frame buffer all-0, res_valid_o=0, res_class_o=0, res_score_o=0, res_scores_o=0, busy_o=0, row_ready_o=0 during reset.
- States: IDLE, LOAD, SETTLE, OUT.
- IDLE:
  - row_ready_o=1.
  - First handshake writes row 0, sets row counter=1, and moves to LOAD.
  - If ROWS==1, that handshake moves straight to SETTLE.
- LOAD:
  - row_ready_o=1.
  - Each handshake writes the row at the row counter index and increments the counter.
  - The handshake on row ROWS-1 moves to SETTLE, loads the settle counter with SETTLE_CYCLES-1, and resets the row counter to 0.
  - Without valid, the state holds; gaps between rows are allowed.
- SETTLE:
  - row_ready_o=0; frame buffer frozen.
  - Settle counter decrements each cycle.
  - When the counter is 0: capture bnn_scores_i into res_scores_o, register the argmax, set res_valid_o=1, and move to OUT.
  - Latency: last-row handshake at cycle t gives res_valid_o=1 first visible at t+1+SETTLE_CYCLES.
- OUT:
  - res_valid_o=1; row_ready_o=0.
  - Result outputs are stable until handshake; the frame buffer is unchanged.
  - On res_ready_i: res_valid_o=0 next cycle and go to IDLE. Result regs keep their last value.
- Argmax: unsigned compare; strict greater-than scan from class 0 upward, so ties resolve to the lowest index.
- Frame buffer is only written on a row handshake; it is never cleared except by reset.
- clear_i:
  - Has priority over all transitions. Next state is IDLE, row/settle counters=0, res_valid_o=0.
  - Frame buffer and result regs are held.
  - A row handshake in the same cycle as clear_i is discarded.
- row_valid_i while not ready: ignored, no side effects.
- Reset mid-frame: partial frame discarded; buffer zeroed.

Optional Feature:
BNN_FRAME_TAG_EN:
- Defined:
  - Adds output res_tag_o [15:0], a frame counter.
  - The counter resets to 0, increments by 1 (wrapping 0xFFFF->0) on each result handshake, and is unaffected by clear_i.
  - res_tag_o equals the counter value latched at capture.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Stream 64 rows with continuous valid; model returns scores {k0=12,k1=40,k2=7}; SETTLE_CYCLES=8 -> res_valid_o high exactly 9 cycles after last handshake, class=1, score=40, all scores echoed.
- Tie: scores {30,30,5} -> class=0, score=30; scores {0,0,0} -> class=0.
- Row gaps and backpressure: random valid gaps during LOAD; hold res_ready_i=0 for 20 cycles -> row_ready_o=0 throughout SETTLE/OUT, result stable, bnn_layer_o equals the streamed frame bit-exact (row r at bits r*64).
- clear_i asserted after row 30, together with a valid row -> IDLE, that row not written; new full frame loads from row 0 and yields a correct result.
- Async reset asserted mid-SETTLE -> all outputs 0 immediately, buffer zero; after release, a normal frame completes.
- With BNN_FRAME_TAG_EN: three back-to-back frames -> tags 0,1,2; preset counter to 0xFFFF -> next tag 0x0000.

Source files
------------

// File: rtl/bnn_frame_ctrl.sv
// Frame sequencer around a combinational BNN: row-wise load, settle wait, score capture and argmax.
// Optional macro BNN_FRAME_TAG_EN adds a 16-bit per-result frame tag output (res_tag_o).
module bnn_frame_ctrl #(
  parameter int ROW_W         = 64,
  parameter int ROWS          = 64,
  parameter int N_CLASS       = 3,
  parameter int SCORE_W       = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int CLS_W         = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [ROW_W-1:0]             row_i,
  input  logic                         row_valid_i,
  output logic                         row_ready_o,
  output logic [ROWS*ROW_W-1:0]        bnn_layer_o,
  input  logic [N_CLASS*SCORE_W-1:0]   bnn_scores_i,
  output logic                         busy_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [CLS_W-1:0]             res_class_o,
  output logic [SCORE_W-1:0]           res_score_o,
  output logic [N_CLASS*SCORE_W-1:0]   res_scores_o
`ifdef BNN_FRAME_TAG_EN
  ,
  output logic [15:0]                  res_tag_o
`endif
);

  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [RC_W-1:0] LAST_ROW  = RC_W'(ROWS - 1);
  localparam logic [SC_W-1:0] SETTLE_LD = SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_OUT    = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [RC_W-1:0]              row_cnt_q, row_cnt_d;
  logic [SC_W-1:0]              settle_cnt_q, settle_cnt_d;
  logic                         row_ready_q, busy_q, res_valid_q;
  logic [ROWS-1:0][ROW_W-1:0]   frame_q;
  logic [CLS_W-1:0]             res_class_q;
  logic [SCORE_W-1:0]           res_score_q;
  logic [N_CLASS*SCORE_W-1:0]   res_scores_q;
  logic                         row_hs_s, res_hs_s, wr_en_s, cap_s;
  logic [CLS_W-1:0]             best_idx_s;
  logic [SCORE_W-1:0]           best_score_s;

  // Ready only ever comes from a register, so it is low throughout reset.
  assign row_hs_s = row_valid_i & row_ready_q;
  assign res_hs_s = res_valid_q & res_ready_i;

  // Next-state, counter and strobe logic; clear_i overrides every transition.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    settle_cnt_d = settle_cnt_q;
    wr_en_s      = 1'b0;
    cap_s        = 1'b0;
    if (clear_i) begin
      state_d      = S_IDLE;
      row_cnt_d    = '0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (row_hs_s) begin
            wr_en_s = 1'b1;
            if (row_cnt_q == LAST_ROW) begin
              state_d      = S_SETTLE;
              row_cnt_d    = '0;
              settle_cnt_d = SETTLE_LD;
            end else begin
              state_d   = S_LOAD;
              row_cnt_d = row_cnt_q + RC_W'(1);
            end
          end else begin
            state_d = state_q;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            cap_s   = 1'b1;
            state_d = S_OUT;
          end else begin
            settle_cnt_d = settle_cnt_q - SC_W'(1);
          end
        end
        S_OUT: begin
          if (res_hs_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_OUT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Argmax: strict greater-than from class 0 upward keeps ties on the lowest index.
  always_comb begin
    best_idx_s   = '0;
    best_score_s = bnn_scores_i[SCORE_W-1:0];
    for (int k = 1; k < N_CLASS; k++) begin
      if (bnn_scores_i[k*SCORE_W +: SCORE_W] > best_score_s) begin
        best_idx_s   = CLS_W'(k);
        best_score_s = bnn_scores_i[k*SCORE_W +: SCORE_W];
      end else begin
        best_idx_s   = best_idx_s;
      end
    end
  end

  // Control registers; status flags are derived from the next state so they stay registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      row_cnt_q    <= '0;
      settle_cnt_q <= '0;
      row_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      row_ready_q  <= (state_d == S_IDLE) || (state_d == S_LOAD);
      busy_q       <= (state_d != S_IDLE);
      res_valid_q  <= (state_d == S_OUT);
    end
  end

  // Frame buffer and result registers: written only on a row handshake / score capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q      <= '0;
      res_class_q  <= '0;
      res_score_q  <= '0;
      res_scores_q <= '0;
    end else begin
      if (wr_en_s) begin
        frame_q[row_cnt_q] <= row_i;
      end
      if (cap_s) begin
        res_class_q  <= best_idx_s;
        res_score_q  <= best_score_s;
        res_scores_q <= bnn_scores_i;
      end
    end
  end

`ifdef BNN_FRAME_TAG_EN
  logic [15:0] tag_cnt_q, res_tag_q;

  // Frame counter advances per consumed result and ignores clear_i; wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_cnt_q <= 16'h0000;
      res_tag_q <= 16'h0000;
    end else begin
      if (res_hs_s) begin
        tag_cnt_q <= tag_cnt_q + 16'h0001;
      end
      if (cap_s) begin
        res_tag_q <= tag_cnt_q;
      end
    end
  end

  assign res_tag_o = res_tag_q;
`endif

  assign row_ready_o  = row_ready_q;
  assign busy_o       = busy_q;
  assign res_valid_o  = res_valid_q;
  assign bnn_layer_o  = frame_q;
  assign res_class_o  = res_class_q;
  assign res_score_o  = res_score_q;
  assign res_scores_o = res_scores_q;

endmodule
